eth_tx_arb: RTL and testbench

Parametrised transmit arbiter between N frame sources (ARP, UDP TX, future ICMP/stats engines) and the single `eth` MAC transmit port. It generalises the fixed two-way priority mux used so far: any channel count, configurable count and data widths, and a registered owner that is held for the whole frame. Rotating (round-robin) priority is available at compile time. The owner's data path is selected by a mux instead of OR-ing all source buses.

---
 rtl/eth_pkg.sv | 14 +
 rtl/eth_rr_pick.sv | 29 ++
 rtl/eth_tx_arb.sv | 126 ++++++++++++
 tb/tb_eth_tx_arb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and default widths for the eth transmit path.
package eth_pkg;

  localparam int unsigned ETH_CNT_W  = 11;
  localparam int unsigned ETH_DATA_W = 8;

  // Arbiter phases: no owner, frame offered to the MAC, MAC sending the frame.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOffer = 2'd1,
    StSend  = 2'd2
  } eth_arb_state_t;

endpackage

// File: rtl/eth_rr_pick.sv
// Rotating priority encoder: returns the first requester at or above base,
// wrapping modulo N_CH.
module eth_rr_pick #(
  parameter int unsigned N_CH = 2
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] base,
  output logic [$clog2(N_CH)-1:0] idx,
  output logic                    any
);

  localparam int unsigned IW = $clog2(N_CH);

  // Scan channels in priority order starting at base; first hit wins.
  always_comb begin
    int unsigned j;
    j   = 0;
    idx = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      j = (32'(base) + k) % N_CH;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// Transmit arbiter between N_CH frame sources and the single MAC tx port.
// The owner is registered in IDLE and held for the whole frame (OFFER+SEND).
// Build option ETH_TX_ARB_RR_EN: round-robin priority base that advances past
// the owner after each completed frame; otherwise channel 0 has fixed top
// priority and no pointer register exists.
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned CNT_W  = ETH_CNT_W,
  parameter int unsigned DATA_W = ETH_DATA_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_CH-1:0]          ch_req,
  input  logic [N_CH*CNT_W-1:0]    ch_count,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  output logic [N_CH-1:0]          ch_grant,
  output logic                     tx_vld,
  output logic [CNT_W-1:0]         tx_count,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(N_CH)-1:0]  owner,
  output logic                     arb_busy
);

  localparam int unsigned OW = $clog2(N_CH);

  eth_arb_state_t state_q, state_d;
  logic [OW-1:0]  owner_q, owner_d;
  logic [OW-1:0]  base;
  logic [OW-1:0]  pick_idx;
  logic           pick_any;

  eth_rr_pick #(
    .N_CH (N_CH)
  ) u_pick (
    .req  (ch_req),
    .base (base),
    .idx  (pick_idx),
    .any  (pick_any)
  );

`ifdef ETH_TX_ARB_RR_EN
  logic [OW-1:0] base_q, base_d;

  // Advance the priority base past the owner once its frame has been sent.
  always_comb begin
    base_d = base_q;
    if (state_q == StSend && !tx_busy) begin
      base_d = (owner_q == OW'(N_CH - 1)) ? '0 : owner_q + OW'(1);
    end
  end

  // Priority base register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      base_q <= '0;
    end else begin
      base_q <= base_d;
    end
  end

  assign base = base_q;
`else
  assign base = '0;
`endif

  // Next state and owner; a withdrawn offer returns to IDLE without touching the base.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          owner_d = pick_idx;
          state_d = StOffer;
        end
      end
      StOffer: begin
        // tx_busy takes precedence over a same-cycle withdrawal.
        if (tx_busy) begin
          state_d = StSend;
        end else if (!ch_req[owner_q]) begin
          state_d = StIdle;
        end
      end
      StSend: begin
        if (!tx_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and owner registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Outputs decoded from the registered state; grant drops as soon as the MAC goes busy.
  always_comb begin
    ch_grant = '0;
    tx_vld   = (state_q == StOffer);
    arb_busy = (state_q != StIdle);
    tx_count = '0;
    tx_data  = '0;
    if (state_q == StOffer) begin
      tx_count = ch_count[owner_q*CNT_W +: CNT_W];
      ch_grant[owner_q] = ~tx_busy;
    end
    if (state_q != StIdle) begin
      tx_data = ch_data[owner_q*DATA_W +: DATA_W];
    end
  end

  assign owner = owner_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Randomised bench for eth_tx_arb (N_CH=4) against a frame-level model.
module tb_eth_tx_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 11;
  localparam int unsigned DW = 8;
  localparam int unsigned OW = 2;
`ifdef ETH_TX_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    ch_req;
  logic [N*CW-1:0] ch_count;
  logic [N*DW-1:0] ch_data;
  logic [N-1:0]    ch_grant;
  logic            tx_vld;
  logic [CW-1:0]   tx_count;
  logic [DW-1:0]   tx_data;
  logic            tx_busy;
  logic [OW-1:0]   owner;
  logic            arb_busy;

  always #5 clk = ~clk;

  eth_tx_arb #(
    .N_CH   (N),
    .CNT_W  (CW),
    .DATA_W (DW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .ch_req   (ch_req),
    .ch_count (ch_count),
    .ch_data  (ch_data),
    .ch_grant (ch_grant),
    .tx_vld   (tx_vld),
    .tx_count (tx_count),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .owner    (owner),
    .arb_busy (arb_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level model: an owner is either absent, offered, or accepted by the MAC.
  bit m_active, m_accepted;
  int m_owner, m_base;
  int mac_left;
  int mode;      // 0 random, 1 all requests held, 2 quiet (only directed requests)
  int rec_q[$];  // owners in the order their frames were offered

  function automatic int winner(input logic [N-1:0] r, input int base);
    int best = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (r[i] && ((i - base + N) % N) < bestd) begin
        bestd = (i - base + N) % N;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_accepted = 1'b0; m_owner = 0; m_base = 0; mac_left = 0;
  endtask

  task automatic model_edge();
    int w;
    if (!m_active) begin
      w = winner(ch_req, m_base);
      if (w >= 0) begin
        m_owner = w; m_active = 1'b1; m_accepted = 1'b0; rec_q.push_back(w);
      end
    end else if (!m_accepted) begin
      if (tx_busy) m_accepted = 1'b1;
      else if (!ch_req[m_owner]) m_active = 1'b0;
    end else if (!tx_busy) begin
      m_active = 1'b0;
      if (RrEn) m_base = (m_owner + 1) % N;
    end
  endtask

  // Sources and MAC behaviour for one cycle.
  task automatic drive();
    bit own_sent;
    for (int i = 0; i < N; i++) begin
      own_sent = m_active && m_accepted && (m_owner == i);
      if (mode == 0) begin
        if (ch_req[i]) begin
          if (own_sent || $urandom_range(15) == 0) ch_req[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          ch_count[i*CW +: CW] = CW'($urandom);
          ch_req[i] = 1'b1;
        end
      end else if (mode == 2 && own_sent) begin
        ch_req[i] = 1'b0;
      end
    end
    ch_data = $urandom;
    if (mac_left > 0) begin
      tx_busy = 1'b1;
      mac_left--;
    end else if (m_active && !m_accepted && (mode == 1 || $urandom_range(2) == 0)) begin
      tx_busy  = 1'b1;
      mac_left = (mode == 0) ? int'($urandom_range(6)) : 4;
    end else begin
      tx_busy = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit      exp_vld;
    logic [N-1:0] exp_grant;
    exp_vld   = m_active && !m_accepted;
    exp_grant = '0;
    if (exp_vld && !tx_busy) exp_grant[m_owner] = 1'b1;
    check_eq("tx_vld", tx_vld, exp_vld);
    check_eq("ch_grant", ch_grant, exp_grant);
    check_eq("tx_count", tx_count, exp_vld ? ch_count[m_owner*CW +: CW] : '0);
    check_eq("tx_data", tx_data, m_active ? ch_data[m_owner*DW +: DW] : '0);
    check_eq("arb_busy", arb_busy, m_active);
    check_eq("owner", owner, m_owner);
  endtask

  // Entered and left at posedge+1.
  task automatic run(input int n);
    repeat (n) begin
      drive();
      #1;
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_vld"}, tx_vld, 1'b0);
    check_eq({tag, "_grant"}, ch_grant, '0);
    check_eq({tag, "_count"}, tx_count, '0);
    check_eq({tag, "_data"}, tx_data, '0);
    check_eq({tag, "_busy"}, arb_busy, 1'b0);
    check_eq({tag, "_owner"}, owner, '0);
  endtask

  initial begin
    resetn   = 1'b0;
    ch_req   = '0;
    ch_count = '0;
    ch_data  = '0;
    tx_busy  = 1'b0;
    mode     = 2;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    ch_req  = '1;
    ch_data = $urandom;
    #1;
    check_all_zero("reset");
    ch_req = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Single request on ch1, then ch0 arrives while ch1 is being sent.
    ch_count[1*CW +: CW] = CW'(60);
    ch_req = 4'b0010;
    run(1);
    check_eq("single_vld_lat", tx_vld, 1'b1);
    check_eq("single_count", tx_count, 60);
    for (int k = 0; k < 50 && !(m_active && m_accepted); k++) run(1);
    check_eq("preempt_in_send", {arb_busy, tx_vld}, 2'b10);
    ch_req[0] = 1'b1;
    for (int k = 0; k < 100 && rec_q.size() < 2; k++) run(1);
    check_eq("preempt_nframes", rec_q.size(), 2);
    if (rec_q.size() >= 2) begin
      check_eq("preempt_first", rec_q[0], 1);
      check_eq("preempt_second", rec_q[1], 0);
    end
    run(20);

    // Random traffic with withdrawals and variable MAC busy time.
    mode = 0;
    run(3000);

    // Reset in the middle of a frame.
    mode = 2;
    ch_req[3] = 1'b1;
    ch_count[3*CW +: CW] = CW'($urandom);
    for (int k = 0; k < 300 && !(m_active && m_accepted); k++) run(1);
    check_eq("midreset_in_send", {arb_busy, tx_vld}, 2'b10);
    resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    ch_req  = '0;
    tx_busy = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // All channels requesting continuously from base 0.
    mode = 1;
    rec_q.delete();
    for (int i = 0; i < N; i++) ch_count[i*CW +: CW] = CW'($urandom);
    ch_req = '1;
    for (int k = 0; k < 300 && rec_q.size() < 5; k++) run(1);
    check_eq("order_nframes", rec_q.size(), 5);
    for (int k = 0; k < 5 && k < rec_q.size(); k++) begin
      check_eq($sformatf("order_%0d", k), rec_q[k], RrEn ? (k % N) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
